// File: rtl/add_pkg.sv
// Shared definitions for the digit-serial adder:
// state encoding and a W/D legality helper.
package add_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   function automatic bit legal(input int w, input int d);
      return (d >= 1) && (d <= w) && ((w % d) == 0);
   endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational D-bit ripple slice built from full-adder cells.
module add_digit #(
   parameter int D = 2
) (
   input  logic [D-1:0] a,
   input  logic [D-1:0] b,
   input  logic         ci,
   output logic [D-1:0] s,
   output logic         co
);

   logic [D:0] cc;

   assign cc[0] = ci;
   assign co    = cc[D];

   for (genvar i = 0; i < D; i++) begin : g_fa
      add_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (cc[i]),
         .s  (s[i]),
         .co (cc[i+1])
      );
   end

endmodule

// File: rtl/add_fa.sv
// One-bit full-adder cell.
module add_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_serial_nb.sv
// Digit-serial adder: z = x + y + ci, D bits per clock,
// with a start/busy/done handshake.
module add_serial_nb
   import add_pkg::*;
#(
   parameter int W = 8,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] z,
   output logic         co
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!legal(W, D)) begin : g_bad
      $error("add_serial_nb: W must be a multiple of D, 1<=D<=W");
   end

   state_t          state;
   logic [W-1:0]    xr;
   logic [W-1:0]    yr;
   logic            cr;
   logic [W-1:0]    acc;
   logic [W-1:0]    acc_nxt;
   logic [CW-1:0]   cnt;
   logic [D-1:0]    s;
   logic            c;

   add_digit #(.D(D)) u_dig (
      .a  (xr[D-1:0]),
      .b  (yr[D-1:0]),
      .ci (cr),
      .s  (s),
      .co (c)
   );

   // Digits enter at the MSB end so digit 0 lands at the bottom.
   if (D == W) begin : g_full
      assign acc_nxt = s;
   end else begin : g_part
      assign acc_nxt = {s, acc[W-1:D]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         z     <= '0;
         co    <= 1'b0;
         xr    <= '0;
         yr    <= '0;
         cr    <= 1'b0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  xr    <= x;
                  yr    <= y;
                  cr    <= ci;
                  cnt   <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               acc <= acc_nxt;
               xr  <= xr >> D;
               yr  <= yr >> D;
               cr  <= c;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  z     <= acc_nxt;
                  co    <= c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_serial_nb.sv
// Directed bench for add_serial_nb across W/D corners.
module tb_add_serial_nb;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic       s8 = 0, c8 = 0;
   logic [7:0] x8 = 0, y8 = 0;
   logic       b8, d8, co8;
   logic [7:0] z8;

   logic       s4 = 0, c4 = 0;
   logic [3:0] x4 = 0, y4 = 0;
   logic       b4, d4, co4;
   logic [3:0] z4;

   logic       sc = 0, cc = 0;
   logic [7:0] xc = 0, yc = 0;
   logic       b1, d1, co1;
   logic [7:0] z1;
   logic       bw, dw, cow;
   logic [7:0] zw;

   int errs = 0;
   int checks = 0;

   add_serial_nb #(.W(8), .D(2)) u_a (
      .clk(clk), .rst(rst), .start(s8),
      .x(x8), .y(y8), .ci(c8),
      .busy(b8), .done(d8), .z(z8), .co(co8)
   );

   add_serial_nb #(.W(4), .D(2)) u_b (
      .clk(clk), .rst(rst), .start(s4),
      .x(x4), .y(y4), .ci(c4),
      .busy(b4), .done(d4), .z(z4), .co(co4)
   );

   add_serial_nb #(.W(8), .D(1)) u_c (
      .clk(clk), .rst(rst), .start(sc),
      .x(xc), .y(yc), .ci(cc),
      .busy(b1), .done(d1), .z(z1), .co(co1)
   );

   add_serial_nb #(.W(8), .D(8)) u_d (
      .clk(clk), .rst(rst), .start(sc),
      .x(xc), .y(yc), .ci(cc),
      .busy(bw), .done(dw), .z(zw), .co(cow)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic add8(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic       c,
      input logic [8:0] e,
      input string      tag
   );
      int nb = 0;
      @(negedge clk);
      s8 = 1; x8 = a; y8 = b; c8 = c;
      @(negedge clk);
      s8 = 0;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      c8 = 1'($urandom);
      for (int i = 0; i < 20 && !d8; i++) begin
         if (b8) nb++;
         @(negedge clk);
      end
      chk({tag, " done"}, 32'(d8), 1);
      chk({tag, " busy"}, nb, 4);
      chk({tag, " sum"}, {co8, z8}, 32'(e));
      @(negedge clk);
      chk({tag, " pulse"}, 32'(d8), 0);
   endtask

   initial begin
      int t[3] = '{0, 0, 0};
      int k = 0;
      int sawd = 0;
      int nd = 0;
      int n1 = 0, nw = 0, nd1 = 0, ndw = 0;
      logic [8:0] r1 = '0, rw = '0;
      logic [4:0] e4;

      @(negedge clk);
      @(negedge clk);
      chk("rst busy", 32'(b8), 0);
      chk("rst done", 32'(d8), 0);
      chk("rst z", {co8, z8}, 0);
      rst = 0;

      add8(8'h3C, 8'h0F, 1'b0, 9'h04B, "t1");
      add8(8'hA5, 8'h5A, 1'b1, 9'h100, "t2a");
      add8(8'hFF, 8'h01, 1'b0, 9'h100, "t2b");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2 hold", {d8, co8, z8}, 10'h100);
      end

      @(negedge clk);
      s8 = 1; x8 = 8'h01; y8 = 8'h01; c8 = 0;
      for (int i = 0; i < 40 && k < 3; i++) begin
         @(negedge clk);
         x8 = b8 ? 8'hFF : 8'h01;
         if (d8) begin
            t[k] = i;
            k++;
            chk("t3 sum", {co8, z8}, 9'h002);
         end
      end
      s8 = 0;
      chk("t3 n", k, 3);
      chk("t3 p1", t[1] - t[0], 6);
      chk("t3 p2", t[2] - t[1], 6);

      repeat (3) @(negedge clk);
      s8 = 1; x8 = 8'h80; y8 = 8'h80; c8 = 0;
      @(negedge clk);
      s8 = 0;
      chk("t4 run", 32'(b8), 1);
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("t4 busy", 32'(b8), 0);
      chk("t4 done", 32'(d8), 0);
      chk("t4 z", {co8, z8}, 0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (d8) sawd++;
      end
      chk("t4 nodone", sawd, 0);
      add8(8'h01, 8'h02, 1'b0, 9'h003, "t4b");

      for (int v = 0; v < 512; v++) begin
         @(negedge clk);
         x4 = 4'(v);
         y4 = 4'(v >> 4);
         c4 = v[8];
         s4 = 1;
         e4 = 5'(x4) + 5'(y4) + 5'(c4);
         @(negedge clk);
         s4 = 0;
         for (int i = 0; i < 10 && !d4; i++) @(negedge clk);
         if (d4) nd++;
         chk("t5 sum", {co4, z4}, 32'(e4));
      end
      chk("t5 count", nd, 512);

      @(negedge clk);
      sc = 1; xc = 8'hFF; yc = 8'hFF; cc = 1;
      @(negedge clk);
      sc = 0; xc = 8'h00; yc = 8'h00; cc = 0;
      for (int i = 0; i < 20; i++) begin
         if (b1) n1++;
         if (bw) nw++;
         if (d1) begin nd1++; r1 = {co1, z1}; end
         if (dw) begin ndw++; rw = {cow, zw}; end
         @(negedge clk);
      end
      chk("t6 d1 run", n1, 8);
      chk("t6 d8 run", nw, 1);
      chk("t6 d1 done", nd1, 1);
      chk("t6 d8 done", ndw, 1);
      chk("t6 d1 sum", r1, 9'h1FF);
      chk("t6 d8 sum", rw, 9'h1FF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/add_serial_nb.md
Name: add_serial_nb

Overview:
- Parametrised digit-serial adder. Computes z = x + y + ci on W-bit operands, D bits per clock, over W/D cycles.
- Operands are presented with a start/busy/done handshake.
- Successor to the fixed-width combinational ripple adders. Trades latency for area: one D-bit ripple slice is reused every cycle.
- Sits behind a simple controller or testbench driver that issues one addition at a time.

Parameters:
- W, 8, operand and result width in bits. Must be a multiple of D.
- D, 2, digit width: bits added per cycle. 1 <= D <= W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new addition; sampled only in IDLE
- x  in  W  operand A; sampled on the accepting edge only
- y  in  W  operand B; sampled on the accepting edge only
- ci  in  1  carry-in; sampled on the accepting edge only
- busy  out  1  high while an addition is in progress (RUN state)
- done  out  1  one-cycle pulse: z/co valid and newly updated
- z  out  W  sum; registered, updated only at completion
- co  out  1  carry-out; registered, updated only at completion

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, z=0, co=0.
  - Operand shift registers, accumulator, carry register and digit counter all 0.
  - Reset asserted mid-operation aborts the addition. No done pulse is produced. z/co return to 0.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE:
  - On an edge with start=1: load xr<=x, yr<=y, cr<=ci, cnt<=0, acc<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Digit sum {c,s} = xr[D-1:0] + yr[D-1:0] + cr, formed by the slice.
  - acc <= {s, acc[W-1:D]}: digits are shifted in from the MSB end, so after W/D steps acc[D-1:0] holds digit 0.
  - xr, yr shift right by D. cr<=c. cnt<=cnt+1.
  - When cnt==W/D-1 on this edge: z<=next acc, co<=c, go to DONE.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally.
- start handling outside IDLE:
  - start in RUN or DONE is ignored. It is not queued.
  - The earliest new accept is the first IDLE cycle after DONE.
- Latency:
  - Accept at edge k; completion at edge k+W/D; done high during the cycle after edge k+W/D.
  - Throughput: one addition per W/D+2 cycles.
- Output hold:
  - z/co hold their last result until the next completion or reset.
  - x/y/ci may change freely after the accepting edge.
- Width rules:
  - Arithmetic is modulo 2^W; overflow appears only on co.
  - cnt width = max(1, $clog2(W/D)).
- D==W: single RUN cycle. Behaves as a registered W-bit adder with 2-cycle handshake overhead.
- D==1: pure bit-serial, W RUN cycles.
- Illegal parameters (W % D != 0, or D > W): elaboration-time error.

Decomposition:
- Shared package (add_pkg):
  - state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2)
  - parameter legality check helper
- Sub-module add_digit #(D): combinational D-bit ripple adder (inputs a, b, ci; outputs s, co), built as a chain of the existing full-adder cell.
- The add_serial_nb top holds the FSM, counter, shift registers and output registers.

Test Plan:
1. W=8, D=2: x=0x3C, y=0x0F, ci=0, start pulse -> busy high for 4 cycles; done pulses once; z=0x4B, co=0.
2. W=8, D=2: x=0xA5, y=0x5A, ci=1 -> z=0x00, co=1. Then x=0xFF, y=0x01, ci=0 -> z=0x00, co=1. z holds 0x00 for 5 idle cycles after done.
3. Handshake, W=8, D=2:
   - Hold start=1 continuously, x=0x01, y=0x01 -> accepts only in IDLE; done every 6 cycles; z=0x02 each time.
   - Change x to 0xFF during RUN -> result unaffected (0x02).
4. Reset mid-operation:
   - Accept x=0x80, y=0x80; assert rst asynchronously (between edges) in the 2nd RUN cycle -> busy/done/z/co go to 0 immediately; no done pulse.
   - After release, a new start for 0x01+0x02 -> z=0x03, co=0.
5. Exhaustive: W=4, D=2; all 512 {x,y,ci} combinations sequentially -> each {co,z} equals x+y+ci; done count = 512.
6. Parameter corners:
   - W=8, D=1: x=0xFF, y=0xFF, ci=1 -> z=0xFF, co=1 after 8 RUN cycles.
   - W=8, D=8, same operands -> same result after 1 RUN cycle.
